// File: rtl/basemul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : basemul_pipe
// Description : Pipelined multi-lane Kyber NTT-domain base-case multiplier.
//               Optional per-lane result accumulation under BASEMUL_ACC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module basemul_pipe #(
    parameter int W     = 16,
    parameter int Q     = 3329,
    parameter int LANES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [LANES*W-1:0] a0,
    input  logic [LANES*W-1:0] a1,
    input  logic [LANES*W-1:0] b0,
    input  logic [LANES*W-1:0] b1,
    input  logic [LANES*W-1:0] gamma,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] c0,
    output logic [LANES*W-1:0] c1,
    output logic               busy
);

    localparam int            PW  = 2 * W;
    localparam int            SW  = 2 * W + 2;
    localparam logic [PW-1:0] Q_P = PW'(Q);
    localparam logic [SW-1:0] Q_S = SW'(Q);

    logic adv;
    logic s1_valid;
    logic s2_valid;

    // Single global advance: every stage moves or every stage holds.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

`ifdef BASEMUL_ACC_EN
    localparam logic [W:0] Q_A = (W + 1)'(Q);

    logic s3_valid;
    logic s1_last;
    logic s2_last;
    logic s3_last;
    logic group_open;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s3_valid   <= 1'b0;
            out_valid  <= 1'b0;
            group_open <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid && s3_last;
            if (s3_valid) begin
                group_open <= !s3_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_last <= in_last;
            s2_last <= s1_last;
            s3_last <= s2_last;
        end
    end

    assign busy = s1_valid || s2_valid || s3_valid || out_valid || group_open;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
        end
    end

    assign busy = s1_valid || s2_valid || out_valid;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [W-1:0]  x0;
        logic [W-1:0]  x1;
        logic [W-1:0]  y0;
        logic [W-1:0]  y1;
        logic [W-1:0]  g;
        logic [PW-1:0] p00;
        logic [PW-1:0] p11;
        logic [PW-1:0] p01;
        logic [PW-1:0] p10;
        logic [W-1:0]  g1;
        logic [W-1:0]  m11;
        logic [PW-1:0] t;
        logic [SW-1:0] s0;
        logic [SW-1:0] s1;
        logic [W-1:0]  lane_c0;
        logic [W-1:0]  lane_c1;

        assign x0 = a0[l*W +: W];
        assign x1 = a1[l*W +: W];
        assign y0 = b0[l*W +: W];
        assign y1 = b1[l*W +: W];
        assign g  = gamma[l*W +: W];

        // Reducing a1*b1 first keeps the twiddle product inside 2W bits.
        assign m11 = W'(p11 % Q_P);
        assign t   = PW'(m11) * PW'(g1);

        always_ff @(posedge clk) begin
            if (adv) begin
                p00 <= PW'(x0) * PW'(y0);
                p11 <= PW'(x1) * PW'(y1);
                p01 <= PW'(x0) * PW'(y1);
                p10 <= PW'(x1) * PW'(y0);
                g1  <= g;
                s0  <= SW'(p00) + SW'(t);
                s1  <= SW'(p01) + SW'(p10);
            end
        end

`ifdef BASEMUL_ACC_EN
        logic [W-1:0] r0;
        logic [W-1:0] r1;
        logic [W-1:0] acc0;
        logic [W-1:0] acc1;
        logic [W:0]   raw0;
        logic [W:0]   raw1;
        logic [W-1:0] sum0;
        logic [W-1:0] sum1;

        always_ff @(posedge clk) begin
            if (adv) begin
                r0 <= W'(s0 % Q_S);
                r1 <= W'(s1 % Q_S);
            end
        end

        // Both addends are below Q, so one conditional subtract is exact.
        assign raw0 = {1'b0, acc0} + {1'b0, r0};
        assign raw1 = {1'b0, acc1} + {1'b0, r1};
        assign sum0 = W'((raw0 >= Q_A) ? raw0 - Q_A : raw0);
        assign sum1 = W'((raw1 >= Q_A) ? raw1 - Q_A : raw1);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc0    <= '0;
                acc1    <= '0;
                lane_c0 <= '0;
                lane_c1 <= '0;
            end else if (adv && s3_valid) begin
                if (s3_last) begin
                    lane_c0 <= sum0;
                    lane_c1 <= sum1;
                    acc0    <= '0;
                    acc1    <= '0;
                end else begin
                    acc0 <= sum0;
                    acc1 <= sum1;
                end
            end
        end
`else
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_c0 <= '0;
                lane_c1 <= '0;
            end else if (adv && s2_valid) begin
                lane_c0 <= W'(s0 % Q_S);
                lane_c1 <= W'(s1 % Q_S);
            end
        end
`endif

        assign c0[l*W +: W] = lane_c0;
        assign c1[l*W +: W] = lane_c1;
    end

endmodule
`default_nettype wire

// File: tb/tb_basemul_pipe.sv
`default_nettype none
// Testbench for basemul_pipe: directed and random beats against an
// arithmetic reference model with an in-order expected-result queue.
`timescale 1ns/1ps
module tb_basemul_pipe;

    localparam int W     = 16;
    localparam int Q     = 3329;
    localparam int LANES = 4;
    localparam int LW    = LANES * W;
`ifdef BASEMUL_ACC_EN
    localparam int L = 4;
`else
    localparam int L = 3;
`endif

    typedef struct packed {
        logic [LW-1:0] c0;
        logic [LW-1:0] c1;
        logic [31:0]   cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [LW-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0, gamma = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [LW-1:0] c0, c1;
    logic          busy;

    basemul_pipe #(.W(W), .Q(Q), .LANES(LANES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .gamma(gamma),
        .out_valid(out_valid), .out_ready(out_ready),
        .c0(c0), .c1(c1), .busy(busy)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    exp_t          q[$];
    longint        macc0[LANES];
    longint        macc1[LANES];
    bit            chk_lat = 1'b1;
    bit            accepted = 1'b0;
    bit            hold_v = 1'b0;
    logic [LW-1:0] hold0, hold1;
    longint        last_c0 = 0, last_c1 = 0;

    task automatic chk(input string tag, input longint got, input longint want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < LANES; l++) begin
            macc0[l] = 0;
            macc1[l] = 0;
        end
    endtask

    // Reference: c0 = a0*b0 + a1*b1*gamma, c1 = a0*b1 + a1*b0, both mod Q.
    task automatic model_accept();
        exp_t   e;
        bit     push;
        longint x0, x1, y0, y1, g, r0, r1;
        e.c0  = '0;
        e.c1  = '0;
        e.cyc = cyc;
        push  = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            x0 = longint'(a0[l*W +: W]);
            x1 = longint'(a1[l*W +: W]);
            y0 = longint'(b0[l*W +: W]);
            y1 = longint'(b1[l*W +: W]);
            g  = longint'(gamma[l*W +: W]);
            r0 = (x0 * y0 + x1 * y1 * g) % Q;
            r1 = (x0 * y1 + x1 * y0) % Q;
`ifdef BASEMUL_ACC_EN
            macc0[l] = (macc0[l] + r0) % Q;
            macc1[l] = (macc1[l] + r1) % Q;
            r0 = macc0[l];
            r1 = macc1[l];
            if (in_last) begin
                macc0[l] = 0;
                macc1[l] = 0;
            end
            push = in_last;
`endif
            e.c0[l*W +: W] = W'(r0);
            e.c1[l*W +: W] = W'(r1);
        end
        if (push) q.push_back(e);
    endtask

    // One clock cycle: observe at the falling edge, then advance past the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
        if (hold_v) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_c0", c0, hold0);
            chk("hold_c1", c1, hold1);
        end
        hold_v = out_valid && !out_ready;
        hold0  = c0;
        hold1  = c1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_output", 1, 0);
            end else begin
                e = q.pop_front();
                chk("c0", c0, e.c0);
                chk("c1", c1, e.c1);
                if (chk_lat) chk("latency", cyc - int'(e.cyc), L);
            end
            last_c0 = longint'(c0[W-1:0]);
            last_c1 = longint'(c1[W-1:0]);
        end
        accepted = in_valid && in_ready;
        if (accepted) model_accept();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_all(input int x0, input int x1, input int y0, input int y1,
                           input int g, input bit last);
        a0      = {LANES{W'(x0)}};
        a1      = {LANES{W'(x1)}};
        b0      = {LANES{W'(y0)}};
        b1      = {LANES{W'(y1)}};
        gamma   = {LANES{W'(g)}};
        in_last = last;
    endtask

    task automatic set_random();
        for (int l = 0; l < LANES; l++) begin
            a0[l*W +: W]    = W'($urandom_range(0, 65535));
            a1[l*W +: W]    = W'($urandom_range(0, 65535));
            b0[l*W +: W]    = W'($urandom_range(0, 65535));
            b1[l*W +: W]    = W'($urandom_range(0, 65535));
            gamma[l*W +: W] = W'($urandom_range(0, 65535));
        end
    endtask

    task automatic send();
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 100 && !accepted; i++) step();
        if (!accepted) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) step();
        chk("drain_empty", q.size(), 0);
        step();
        step();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_c0", c0, 0);
        chk("reset_c1", c1, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", in_ready, 1);

        // Basic product, single beat, latency checked by the scoreboard.
        set_all(1, 0, 5, 7, 17, 1'b1);
        send();
        drain();
        chk("basic_c0", last_c0, 5);
        chk("basic_c1", last_c1, 7);

        // Wrap-around with operands at Q-1 and at the W-bit maximum.
        set_all(3328, 3328, 3328, 3328, 3328, 1'b1);
        send();
        drain();
        chk("wrap_q_c0", last_c0, 0);
        chk("wrap_q_c1", last_c1, 2);
        set_all(65535, 65535, 65535, 65535, 65535, 1'b1);
        send();
        drain();
        chk("wrap_max_c0", last_c0, 1872);
        chk("wrap_max_c1", last_c1, 226);

        // Lane independence: same beat twice, second with one lane altered.
        set_random();
        in_last = 1'b1;
        send();
        a0[2*W +: W] = a0[2*W +: W] ^ 16'h0155;
        gamma[2*W +: W] = gamma[2*W +: W] + 16'd3;
        send();
        drain();

        // Backpressure: eight back-to-back beats, downstream stalls mid-stream.
        begin
            int k;
            k = 0;
            chk_lat = 1'b0;
            for (int i = 0; i < 40 && (k < 8 || q.size() > 0); i++) begin
                out_ready = !(i >= 4 && i <= 8);
                if (k < 8) begin
                    set_all(k, 0, 1, 0, 0, 1'b1);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                step();
                if (accepted) k++;
            end
            chk("bp_beats_accepted", k, 8);
            drain();
            chk("bp_last_c0", last_c0, 7);
        end

        // Random traffic with random valid, ready and group boundaries.
        for (int i = 0; i < 80; i++) begin
            set_random();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            in_last   = ($urandom_range(0, 3) == 0);
            step();
        end
        drain();

        // Asynchronous reset with beats in flight.
        chk_lat = 1'b1;
        set_random();
        in_last = 1'b1;
        send();
        send();
        send();
        in_valid = 1'b0;
        chk("busy_inflight", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        q.delete();
        model_reset();
        hold_v = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        set_all(2, 3, 4, 5, 6, 1'b1);
        send();
        drain();
        chk("post_rst_c0", last_c0, (2 * 4 + 3 * 5 * 6) % Q);
        chk("post_rst_c1", last_c1, (2 * 5 + 3 * 4) % Q);

`ifdef BASEMUL_ACC_EN
        set_all(1, 0, 5, 7, 17, 1'b0);
        send();
        send();
        in_last = 1'b1;
        send();
        drain();
        chk("acc3_c0", last_c0, 15);
        chk("acc3_c1", last_c1, 21);
        set_all(1, 0, 3328, 0, 0, 1'b0);
        for (int i = 0; i < 999; i++) send();
        in_last = 1'b1;
        send();
        drain();
        chk("acc1000_c0", last_c0, 2329);
        chk("acc1000_c1", last_c1, 0);
`endif

        chk("final_busy", busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/basemul_pipe.md
# basemul_pipe

Pipelined, multi-lane NTT-domain base-case multiplier for the Kyber datapath. Per lane it computes c0 = (a0·b0 + a1·b1·γ) mod Q and c1 = (a0·b1 + a1·b0) mod Q over degree-1 polynomial pairs. Results are exactly reduced to [0, Q−1]. It streams one coefficient-pair beat per lane per cycle with valid/ready backpressure, and sits between the NTT-domain coefficient buffers and the polynomial-vector accumulation logic.

## Interface
- W, 16: coefficient width in bits.
- Q, 3329: modulus; requires Q < 2^W.
- LANES, 1: independent parallel lanes. Lane i uses bits [i·W +: W] of every packed bus.
- clk  in  1: clock, rising edge.
- rst  in  1: reset, asynchronous, active-high.
- in_valid  in  1: input beat valid.
- in_ready  out  1: block accepts a beat this cycle.
- in_last  in  1: last beat of an accumulation group. Ignored when accumulation is compiled out.
- a0, a1, b0, b1  in  LANES·W each: coefficient operands.
- gamma  in  LANES·W: per-lane twiddle γ.
- out_valid  out  1: result beat valid.
- out_ready  in  1: downstream accepts the result.
- c0, c1  out  LANES·W each: reduced results.
- busy  out  1: any stage valid, or an accumulation group is open.

## Operation
- A beat is accepted on a rising edge where in_valid && in_ready.
- A result is consumed on a rising edge where out_valid && out_ready.
- Pipeline stages:
  - S1: four W×W products a0b0, a1b1, a0b1, a1b0, each 2W bits wide.
  - S2: t = (a1b1 mod Q)·γ. Sums s0 = a0b0 + t and s1 = a0b1 + a1b0; intermediates are ≥ 2W+2 bits.
  - S3: s0 mod Q and s1 mod Q into the output register.
- Reduction is exact for any W-bit operand values, including operands ≥ Q. Output is always in [0, Q−1]. The reduction method (Barrett or conditional subtract) is implementation choice, provided it is bit-exact.
- Lanes share control and never interact.
- Global advance: adv = !out_valid || out_ready. in_ready = adv.
- When adv = 0, every stage register holds and its valid bit holds.
- Bubbles (stage valid = 0) travel with the data. They are never emitted and never compressed while stalled.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- Reset values: all stage valid bits 0, out_valid 0, c0 = c1 = 0, accumulators 0, busy 0.
  - In-flight beats are discarded on reset.
  - in_ready = 1 from the first cycle after reset deassertion.
- Stage data registers may skip reset; valid bits and outputs must not.

## Timing
- Latency L = 3 cycles (accumulation compiled out).
  - A beat accepted at edge N gives out_valid = 1 after edge N+3, provided there is no stall.
- Throughput is one beat per cycle with out_ready held high.
- out_valid with c0/c1 stays stable until consumed.
- in_ready is combinational from out_ready and out_valid. There is no combinational path from in_valid to out_valid.
- Simultaneous accept and consume in the same cycle is permitted and required when adv = 1.
- A full stall holds at most L beats internally.

## Configuration
- Macro: BASEMUL_ACC_EN.
- Defined:
  - Adds a stage S4 with per-lane accumulators acc0, acc1, each W bits.
  - On every advancing valid beat, acc ← (acc + r) mod Q via one conditional subtract.
  - out_valid asserts only for beats tagged in_last. The output is the accumulated sum including that beat.
  - The accumulators clear to 0 in the same edge the result is loaded.
  - Non-last beats produce no output.
  - L = 4.
  - busy stays high while a group is open, i.e. between the first beat and its last.
- Undefined:
  - No S4, L = 3.
  - in_last is ignored.
  - Every beat produces one output.

## Test plan
- Basic product, Q = 3329, LANES = 1: a0 = 1, a1 = 0, b0 = 5, b1 = 7, γ = 17 → c0 = 5, c1 = 7, out_valid exactly 3 cycles after accept.
- Wrap-around: a0 = a1 = b0 = b1 = γ = 3328 → c0 = 0, c1 = 2. Then a0 = a1 = b0 = b1 = γ = 65535 → c0 = 65535³ + 65535² mod 3329, c1 = 2·65535² mod 3329.
- Backpressure: 8 back-to-back beats (a0 = k, b0 = 1, others 0) with out_ready low for cycles 4–8 → in_ready low during the stall, c0 sequence 0..7 in order, no loss or duplication.
- Lanes, LANES = 4: distinct random operands per lane against a golden model → every lane matches. Altering one lane's inputs leaves the other lanes' outputs unchanged.
- Reset mid-stream: assert rst with 3 beats in flight → out_valid = 0 and busy = 0 immediately (asynchronous). After release the next beat emerges with correct latency and no stale data.
- Accumulate (BASEMUL_ACC_EN): 3 beats each giving c0 = 5, c1 = 7, in_last on the third → a single output c0 = 15, c1 = 21. A following group of 1000 beats with c0 = 3328 → c0 = 3328·1000 mod 3329 = 2329.
